// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU, the result FIFO and the writeback consumer.
// master = environment side (ALU + consumer), slave = FIFO side.
interface alu_result_fifo_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] result;
  logic              cout;
  logic              bout;
  logic [OP_W-1:0]   opcode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [OP_W-1:0]   out_opcode;
  logic              out_cout;
  logic              out_bout;
  logic              out_zero;
  logic              out_neg;
  logic [CW-1:0]     count;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output in_valid, result, cout, bout, opcode, out_ready,
    input  in_ready, out_valid, out_result, out_opcode, out_cout, out_bout,
           out_zero, out_neg, count, drop_cnt
  );

  modport slave (
    input  in_valid, result, cout, bout, opcode, out_ready,
    output in_ready, out_valid, out_result, out_opcode, out_cout, out_bout,
           out_zero, out_neg, count, drop_cnt
  );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO capturing ALU results with zero/negative flags;
// results arriving while full are dropped and counted (saturating).
module alu_result_fifo #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_result_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [OP_W-1:0]   opcode;
    logic              cout;
    logic              bout;
    logic              zero;
    logic              neg;
  } entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_drop_cnt;
  entry_t           r_mem [DEPTH];

  logic   w_in_ready;
  logic   w_out_valid;
  logic   w_push;
  logic   w_pop;
  logic   w_drop;
  entry_t w_wr_entry;
  entry_t w_head;

  // Acceptance depends only on registered occupancy; a pop never frees a slot
  // for the same cycle's push.
  assign w_in_ready  = (r_count != CW'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_drop      = bus.in_valid & ~w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;

  always_comb begin
    w_wr_entry        = '0;
    w_wr_entry.result = bus.result;
    w_wr_entry.opcode = bus.opcode;
    w_wr_entry.cout   = bus.cout;
    w_wr_entry.bout   = bus.bout;
    w_wr_entry.zero   = (bus.result == '0);
    w_wr_entry.neg    = bus.result[DATA_W-1];
  end

  // Storage carries no reset; validity is tracked purely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  assign w_head = w_out_valid ? r_mem[r_rd_ptr] : '0;

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_result = w_head.result;
  assign bus.out_opcode = w_head.opcode;
  assign bus.out_cout   = w_head.cout;
  assign bus.out_bout   = w_head.bout;
  assign bus.out_zero   = w_head.zero;
  assign bus.out_neg    = w_head.neg;
  assign bus.count      = r_count;
  assign bus.drop_cnt   = r_drop_cnt;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized and directed bench for alu_result_fifo with a queue-based
// reference model and a decoupled negedge monitor.
module tb_alu_result_fifo;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_fifo_if #(.DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  alu_result_fifo #(.DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [DATA_W-1:0] r;
    logic [OP_W-1:0]   op;
    logic              c;
    logic              b;
  } item_t;

  item_t exp_q[$];
  int    exp_drops = 0;
  int    n_checks  = 0;
  int    n_pass    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain queue of accepted results plus a drop tally.
  always @(negedge rst_n) begin
    exp_q.delete();
    exp_drops = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      int  sz;
      bit  do_pop;
      sz     = exp_q.size();
      do_pop = bus.out_ready && (sz != 0);
      if (bus.in_valid) begin
        if (sz < DEPTH) exp_q.push_back('{bus.result, bus.opcode, bus.cout, bus.bout});
        else if (exp_drops < CNT_MAX) exp_drops++;
      end
      if (do_pop) void'(exp_q.pop_front());
    end
  end

  // Monitor: compares everything the DUT presents against the model, mid-cycle.
  always @(negedge clk) begin
    logic [39:0] exp_head;
    logic [39:0] act_head;
    int sz;
    sz = exp_q.size();
    if (sz != 0)
      exp_head = {exp_q[0].r, exp_q[0].op, exp_q[0].c, exp_q[0].b,
                  (exp_q[0].r == '0), exp_q[0].r[DATA_W-1]};
    else
      exp_head = '0;
    act_head = {bus.out_result, bus.out_opcode, bus.out_cout, bus.out_bout,
                bus.out_zero, bus.out_neg};
    check("out_valid", 64'(bus.out_valid), 64'(sz != 0));
    check("in_ready",  64'(bus.in_ready),  64'(sz != DEPTH));
    check("count",     64'(bus.count),     64'(sz));
    check("drop_cnt",  64'(bus.drop_cnt),  64'(exp_drops));
    check("head",      64'(act_head),      64'(exp_head));
  end

  task automatic step(input bit v, input logic [DATA_W-1:0] r, input logic [OP_W-1:0] op,
                      input bit c, input bit b, input bit rdy);
    bus.in_valid  = v;
    bus.result    = r;
    bus.opcode    = op;
    bus.cout      = c;
    bus.bout      = b;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, '0, '0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    logic [DATA_W-1:0] r;
    bit v, rdy;
    int rdy_bias;
    bus.in_valid = 0; bus.result = '0; bus.opcode = '0;
    bus.cout = 0; bus.bout = 0; bus.out_ready = 0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset/idle state
    check("rst_count",     64'(bus.count),      64'd0);
    check("rst_in_ready",  64'(bus.in_ready),   64'd1);
    check("rst_out_valid", 64'(bus.out_valid),  64'd0);
    check("rst_drop",      64'(bus.drop_cnt),   64'd0);
    check("rst_result",    64'(bus.out_result), 64'd0);

    // Single pass-through
    step(1'b1, 32'd15, 4'd0, 1'b0, 1'b0, 1'b1);
    check("sp_valid",  64'(bus.out_valid),  64'd1);
    check("sp_result", 64'(bus.out_result), 64'd15);
    check("sp_zero",   64'(bus.out_zero),   64'd0);
    check("sp_neg",    64'(bus.out_neg),    64'd0);
    idle(1'b1);
    check("sp_count0", 64'(bus.count), 64'd0);

    // Flags
    step(1'b1, 32'h0000_0000, 4'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hFFFF_FFFB, 4'd1, 1'b0, 1'b1, 1'b0);
    check("fl_zero1", 64'(bus.out_zero), 64'd1);
    idle(1'b1);
    check("fl_neg2",  64'(bus.out_neg),  64'd1);
    check("fl_bout2", 64'(bus.out_bout), 64'd1);
    check("fl_zero2", 64'(bus.out_zero), 64'd0);
    idle(1'b1);

    // Fill and drop
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, DATA_W'(i), 4'd2, 1'b0, 1'b0, 1'b0);
      if (i == 4) begin
        check("fill_count4", 64'(bus.count),    64'd4);
        check("fill_rdy0",   64'(bus.in_ready), 64'd0);
      end
    end
    idle(1'b0);
    check("fill_drop2", 64'(bus.drop_cnt), 64'd2);
    for (int i = 1; i <= 4; i++) begin
      check("drain_val", 64'(bus.out_result), 64'(i));
      idle(1'b1);
    end
    check("drain_empty", 64'(bus.count), 64'd0);

    // Simultaneous push/pop at count 2, across pointer wrap
    step(1'b1, 32'd100, 4'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'd101, 4'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("pp_head", 64'(bus.out_result), 64'(100 + i));
      step(1'b1, DATA_W'(102 + i), 4'd3, 1'b1, 1'b0, 1'b1);
      check("pp_count", 64'(bus.count), 64'd2);
    end

    // Asynchronous reset mid-clock with entries queued
    idle(1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("ar_valid",    64'(bus.out_valid), 64'd0);
    check("ar_count",    64'(bus.count),     64'd0);
    check("ar_drop",     64'(bus.drop_cnt),  64'd0);
    check("ar_in_ready", 64'(bus.in_ready),  64'd1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Drop counter saturation; contents must survive
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hA0 + DATA_W'(i), 4'd5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 32'hDEAD_0000 + DATA_W'(i), 4'd6, 1'b1, 1'b0, 1'b0);
    check("sat_drop",  64'(bus.drop_cnt), 64'(CNT_MAX));
    check("sat_count", 64'(bus.count),    64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      check("sat_content", 64'(bus.out_result), 64'(32'hA0 + i));
      idle(1'b1);
    end

    // Randomized traffic; the monitor/model scoreboard does the checking
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    rdy_bias = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rdy_bias = $urandom_range(0, 3);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) < rdy_bias);
      case ($urandom_range(0, 3))
        0:       r = '0;
        1:       r = 32'h8000_0000 | DATA_W'($urandom);
        default: r = DATA_W'($urandom);
      endcase
      step(v, r, OP_W'($urandom), 1'($urandom), 1'($urandom), rdy);
    end
    for (int i = 0; i <= DEPTH; i++) idle(1'b1);
    check("final_empty", 64'(bus.count), 64'd0);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the 32-bit ALU; captures each enabled ALU result (result, cout, bout, opcode) into a small first-word-fall-through FIFO.
- Generates zero/negative flags at capture time.
- Presents entries to the consumer (writeback/register-file stage) over a valid/ready handshake.
- Counts results lost when the ALU fires while the FIFO is full, since the ALU itself has no backpressure.

Parameters:
- DATA_W, 32, width of ALU result and stored data.
- OP_W, 4, width of ALU opcode tag.
- DEPTH, 4, number of entries; power of two, >= 2.
- CNT_W, 8, width of saturating drop counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result valid; driven from the ALU's en.
- in_ready  output  1  FIFO can accept this cycle.
- result  input  DATA_W  ALU result bus.
- cout  input  1  ALU carry out.
- bout  input  1  ALU borrow out.
- opcode  input  OP_W  opcode that produced result.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer takes head entry.
- out_result  output  DATA_W  head result.
- out_opcode  output  OP_W  head opcode.
- out_cout  output  1  head carry.
- out_bout  output  1  head borrow.
- out_zero  output  1  head result == 0.
- out_neg  output  1  head result MSB.
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- drop_cnt  output  CNT_W  results dropped while full, saturating.

Behaviour:
- Reset (async, rst_n=0): wr_ptr=rd_ptr=0, count=0, drop_cnt=0, out_valid=0. All out_* data outputs read 0. Storage array is not reset. in_ready=1 while in reset. Reset mid-operation discards all entries immediately.
- in_ready = (count != DEPTH), combinational from registered count only; no dependence on out_ready. No push-through-when-full bypass.
- push = in_valid & in_ready. On push, write {result, opcode, cout, bout, zero=(result==0), neg=result[DATA_W-1]} at wr_ptr, then wr_ptr = wr_ptr+1 mod DEPTH.
- drop = in_valid & ~in_ready. drop_cnt increments by 1 per dropped cycle and holds at 2^CNT_W-1. The entry is discarded and FIFO state is unchanged.
- out_valid = (count != 0). out_* show the entry at rd_ptr combinationally (FWFT). When empty, out_* data outputs are forced to 0.
- pop = out_valid & out_ready. On pop, rd_ptr = rd_ptr+1 mod DEPTH. out_ready while empty is ignored.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle (legal when 0<count<DEPTH): unchanged
  - Full with pop: push is blocked (in_ready=0) even though a slot frees; count becomes DEPTH-1 and in_ready=1 next cycle.
- Latency: result accepted at edge N is visible on out_* with out_valid=1 after edge N; single-entry pass-through is one cycle.
- Ordering strictly FIFO; pointer wrap is transparent.
- Flags are computed on the captured value and never recomputed.

Test Plan:
- Reset/idle: assert rst_n=0 mid-clock with 2 entries queued -> out_valid=0, count=0, drop_cnt=0, in_ready=1 immediately, without waiting for an edge.
- Single pass: push result=15 (10+5), opcode=0, cout=0, out_ready=1 -> next cycle out_valid=1, out_result=15, out_zero=0, out_neg=0. Popped that cycle, so count returns to 0 the following cycle.
- Flags: push 0x00000000 then 0xFFFFFFFB (5-10), bout=1 -> head 1 shows out_zero=1. After pop, head 2 shows out_neg=1, out_bout=1, out_zero=0.
- Fill/drop: out_ready=0, push 6 consecutive results 1..6 with DEPTH=4:
  - count=4 and in_ready=0 after the 4th push.
  - drop_cnt=2.
  - Draining yields exactly 1,2,3,4.
- Simultaneous push/pop at count=2 for 10 cycles with incrementing data -> count stays 2. Output sequence is in order across pointer wrap.
- Drop saturation: hold full with in_valid=1 for 300 cycles, CNT_W=8 -> drop_cnt=255 and stays 255; FIFO contents unchanged.
